// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for a 32-bit combinational ALU: one instruction at a time,
// four cycles per instruction (accept, decode, execute, writeback).
module alu_issue_ctrl #(
  parameter int NREGS = 16,
  parameter int IMM_W = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic [1:0]  alu_flags,
  output logic        done,
  output logic        illegal,
  output logic        div_zero,
  output logic        flag_eq,
  output logic        flag_gt,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;
  localparam logic [4:0] OP_CMP = 5'b00101;
  localparam logic [4:0] OP_NOP = 5'b01101;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t      state_q;
  logic [31:0] instr_q;
  logic [31:0] res_q;
  logic [1:0]  flags_q;
  logic        in_ready_q;
  logic [4:0]  alu_op_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic        done_q;
  logic        illegal_q;
  logic        div_zero_q;
  logic        flag_eq_q;
  logic        flag_gt_q;
  logic [31:0] regs_q [NREGS];

  logic [4:0]  op_d;
  logic        imm_sel_d;
  logic [3:0]  rd_d;
  logic [3:0]  rs1_d;
  logic [3:0]  rs2_d;
  logic [31:0] imm_d;
  logic [31:0] rs1_val_d;
  logic [31:0] rs2_val_d;
  logic [31:0] opb_d;
  logic        illegal_d;
  logic        div_zero_d;
  logic        wr_en_d;

  assign op_d      = instr_q[31:27];
  assign imm_sel_d = instr_q[26];
  assign rd_d      = instr_q[25:22];
  assign rs1_d     = instr_q[21:18];
  assign rs2_d     = instr_q[17:14];
  assign imm_d     = {{(32-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};

  assign rs1_val_d = (rs1_d == 4'd0) ? 32'd0 : regs_q[rs1_d];
  assign rs2_val_d = (rs2_d == 4'd0) ? 32'd0 : regs_q[rs2_d];
  assign opb_d     = imm_sel_d ? imm_d : rs2_val_d;

  // Error conditions are judged from the issued operands, which stay stable through WB.
  assign illegal_d  = (alu_op_q > OP_NOP);
  assign div_zero_d = ((alu_op_q == OP_DIV) || (alu_op_q == OP_MOD)) && (alu_b_q == 32'd0);
  assign wr_en_d    = (state_q == S_WB) && (alu_op_q < OP_NOP) && (alu_op_q != OP_CMP)
                      && !div_zero_d && (rd_d != 4'd0);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    always_ff @(posedge clk) begin
      if (reset) begin
        regs_q[gi] <= '0;
      end else if (wr_en_d && (rd_d == 4'(gi))) begin
        regs_q[gi] <= res_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      in_ready_q <= 1'b1;
      alu_op_q   <= OP_NOP;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      div_zero_q <= 1'b0;
      flag_eq_q  <= 1'b0;
      flag_gt_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            instr_q    <= in_instr;
            in_ready_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_op_q <= op_d;
          alu_a_q  <= rs1_val_d;
          alu_b_q  <= opb_d;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          // Status pulses are registered here so they coincide with the WB cycle.
          res_q      <= alu_res;
          flags_q    <= alu_flags;
          done_q     <= 1'b1;
          illegal_q  <= illegal_d;
          div_zero_q <= div_zero_d;
          state_q    <= S_WB;
        end
        S_WB: begin
          if (alu_op_q == OP_CMP) begin
            flag_eq_q <= flags_q[0];
            flag_gt_q <= flags_q[1];
          end
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign alu_op   = alu_op_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign div_zero = div_zero_q;
  assign flag_eq  = flag_eq_q;
  assign flag_gt  = flag_gt_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue/writeback sequencer that drives the 32-bit combinational ALU from the initiator side. It accepts one instruction word at a time over a valid/ready handshake and decodes it to the 5-bit ALU opcode. It reads operands from an internal 16x32 register file, presents them to the ALU, and captures the result and compare flags. It then writes back to the register file or the flag register, and signals completion.

Parameters:
NREGS, 16, register file depth (fixed at 16; 4-bit register fields)
IMM_W, 18, immediate field width, sign-extended to 32

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  instruction word valid
in_ready  out  1  sequencer idle, can accept
in_instr  in  32  [31:27] op, [26] imm_sel, [25:22] rd, [21:18] rs1, [17:14] rs2, [17:0] imm
alu_op  out  5  ALU opcode (registered)
alu_a  out  32  ALU operand a (registered)
alu_b  out  32  ALU operand b (registered)
alu_res  in  32  ALU result
alu_flags  in  2  ALU flags: [0]=equal, [1]=greater (signed)
done  out  1  one-cycle pulse, instruction retired
illegal  out  1  one-cycle pulse with done, op > 5'b01101
div_zero  out  1  one-cycle pulse with done, div/mod with b==0
flag_eq  out  1  architectural equal flag
flag_gt  out  1  architectural greater flag
dbg_addr  in  4  register file debug read address
dbg_data  out  32  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all 16 registers=0; flag_eq=flag_gt=0; alu_op=5'b01101 (nop); alu_a=alu_b=0; done=illegal=div_zero=0; in_ready=1 on the first cycle after reset. Reset in any state aborts the instruction in flight with no writeback and no done.
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE: in_ready=1; on in_valid & in_ready, latch in_instr -> DECODE. in_ready=0 in all other states.
  - DECODE: alu_op<=op; alu_a<=R[rs1]; alu_b<=imm_sel ? sext(imm) : R[rs2] -> EXEC.
  - EXEC: ALU settles; capture alu_res and alu_flags into internal registers -> WB.
  - WB: perform writeback; assert done for exactly this cycle -> IDLE.
- Latency: accept at cycle N; done at N+3; in_ready high again at N+4. Throughput is one instruction per 4 cycles.
- Writeback rules in WB:
  - op 00000-00100, 00110-01100: R[rd]<=captured result, unless rd==0.
  - op 00101 (cmp): no register write; flag_eq<=flags[0], flag_gt<=flags[1].
  - op 01101 (nop): nothing written; done still pulses.
  - op > 01101: nothing written; illegal=1 with done.
  - op 00011/00100 with alu_b==0: nothing written; div_zero=1 with done.
- Flag register changes only on cmp.
- R0 reads as 0 always, and writes to it are discarded.
- Operand semantics: not uses alu_a only; mov uses alu_b only. Both operands are still driven from the fields regardless.
- Immediate: imm[17] sign-extends to bits 31:18. When imm_sel=1, rs2 is ignored.
- Read-after-write: an instruction accepted after done sees the written value. No bypass is needed, since issue is strictly serialized.
- alu_op/alu_a/alu_b hold their last values in IDLE and WB.
- in_valid while busy is ignored; the upstream holds the word until in_ready.
- dbg_data reflects a WB write from the cycle after WB.

Test Plan:
- Reset then immediate loads: mov imm r1=5, mov imm r2=-3 (imm=18'h3FFFD) -> dbg r1=32'h5, r2=32'hFFFFFFFD; done 3 cycles after each accept; in_ready low for 3 cycles.
- Arithmetic: add r3=r1+r2 -> r3=2; mul r4=r1*r1 -> 25; asr r5=r2>>>1 -> 32'hFFFFFFFE; lsr r6=r2>>1 -> 32'h7FFFFFFE.
- Compare: cmp r1,r1 -> flag_eq=1, flag_gt=0; cmp r1,r2 -> flag_eq=0, flag_gt=1; cmp r2,r1 -> 0/0; registers unchanged.
- Error paths: div r7=r1/r0 -> div_zero pulse with done, r7 stays 0; op 5'b11111 -> illegal pulse, no register or flag change; add with rd=0 -> r0 stays 0.
- Handshake: hold in_valid high continuously across 3 instructions -> exactly 3 done pulses, accepts spaced 4 cycles apart; in_valid low -> FSM stays in IDLE.
- Reset mid-operation: assert reset in EXEC of add r8=r1+r1 -> no done; r8=0; all registers and flags 0; in_ready=1 the cycle after reset deasserts.
